// File: rtl/l1d_cache.sv
// l1d_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// Sits between the hart data port and block RAM; both sides are Wishbone
// pipelined, with at most one request outstanding at a time.
//
// Handshake: the hart request is accepted on a rising edge where
// i_cpu_stb=1 and o_cpu_stall=0. It completes with a 1-cycle o_cpu_ack,
// with o_cpu_data valid in that cycle and 0 at every other time. On the
// memory side a beat is taken on an edge where o_mem_stb=1 and
// i_mem_stall=0. Completion is the first i_mem_ack seen after that edge.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_invalidate          pulse: clear every valid bit at the next edge
//   i_cpu_*               hart request (stb, we, sel, addr, data)
//   o_cpu_data/ack/stall  hart response
//   o_mem_*               block RAM request (stb, we, sel, addr, data)
//   i_mem_data/ack/stall  block RAM response
module l1d_cache #(
  parameter int XLEN  = 32,
  parameter int LINES = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_invalidate,
  input  logic            i_cpu_stb,
  input  logic            i_cpu_we,
  input  logic [3:0]      i_cpu_sel,
  input  logic [XLEN-1:0] i_cpu_addr,
  input  logic [XLEN-1:0] i_cpu_data,
  output logic [XLEN-1:0] o_cpu_data,
  output logic            o_cpu_ack,
  output logic            o_cpu_stall,
  output logic            o_mem_stb,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_sel,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_data,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_ack,
  input  logic            i_mem_stall
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = XLEN - 2 - IDX;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   data_q [LINES];
  logic [XLEN-1:0]   data_d [LINES];
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [TAGW-1:0]   tag_d  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [IDX-1:0]    cpu_idx, req_idx;
  logic [TAGW-1:0]   cpu_tag, req_tag;
  logic              hit;

  assign cpu_idx = i_cpu_addr[2 +: IDX];
  assign cpu_tag = i_cpu_addr[XLEN-1 : 2+IDX];
  assign req_idx = addr_q[2 +: IDX];
  assign req_tag = addr_q[XLEN-1 : 2+IDX];
  assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (i_cpu_stb) begin
          if (!i_cpu_we && hit) begin
            // Read hit: answered from the array next cycle, bus untouched.
            ack_d   = 1'b1;
            rdata_d = data_q[cpu_idx];
          end else begin
            // Write-through: a write hit updates the line now; the bus
            // write goes out regardless. A write miss leaves the array alone.
            if (i_cpu_we && hit) begin
              for (int b = 0; b < 4; b++) begin
                if (i_cpu_sel[b]) data_d[cpu_idx][8*b +: 8] = i_cpu_data[8*b +: 8];
              end
            end
            addr_d  = i_cpu_addr;
            we_d    = i_cpu_we;
            sel_d   = i_cpu_we ? i_cpu_sel : 4'hF;
            wdata_d = i_cpu_we ? i_cpu_data : '0;
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (!i_mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          if (!we_q) begin
            data_d[req_idx]  = i_mem_data;
            tag_d[req_idx]   = req_tag;
            valid_d[req_idx] = 1'b1;
            rdata_d          = i_mem_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Invalidate wins over a same-cycle fill or merge: data may change but
    // the line is left invalid.
    if (i_invalidate) valid_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < LINES; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign o_cpu_ack   = ack_q;
  assign o_cpu_data  = rdata_q;
  assign o_cpu_stall = (state_q != IDLE);
  assign o_mem_stb   = (state_q == MEM_REQ);
  assign o_mem_we    = o_mem_stb & we_q;
  assign o_mem_sel   = sel_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = wdata_q;

endmodule

// File: tb/tb_l1d_cache.sv
// Bench for l1d_cache: directed requests, a block RAM model and a scoreboard
// monitor comparing every o_cpu_ack against an expected-data queue.
module tb_l1d_cache;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_invalidate = 1'b0;
  logic        i_cpu_stb = 1'b0;
  logic        i_cpu_we = 1'b0;
  logic [3:0]  i_cpu_sel = 4'h0;
  logic [31:0] i_cpu_addr = '0;
  logic [31:0] i_cpu_data = '0;
  logic [31:0] o_cpu_data;
  logic        o_cpu_ack;
  logic        o_cpu_stall;
  logic        o_mem_stb;
  logic        o_mem_we;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data = '0;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_stall = 1'b0;

  l1d_cache #(.XLEN(32), .LINES(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_invalidate(i_invalidate),
    .i_cpu_stb(i_cpu_stb), .i_cpu_we(i_cpu_we), .i_cpu_sel(i_cpu_sel),
    .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .o_cpu_data(o_cpu_data), .o_cpu_ack(o_cpu_ack), .o_cpu_stall(o_cpu_stall),
    .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack), .i_mem_stall(i_mem_stall)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int stb_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- block RAM model ----------------
  logic [31:0] mem [int];
  int          stall_left = 0;
  logic        ack_pending = 1'b0;
  logic [31:0] ack_data = '0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_sel = '0;
  logic        last_we = 1'b0;

  initial begin
    forever begin
      @(negedge i_clk);
      i_mem_ack  = 1'b0;
      i_mem_data = '0;
      if (ack_pending) begin
        i_mem_ack   = 1'b1;
        i_mem_data  = ack_data;
        ack_pending = 1'b0;
      end
      if (o_mem_stb && stall_left > 0) begin
        i_mem_stall = 1'b1;
        stall_left--;
      end else begin
        i_mem_stall = 1'b0;
      end
      // Beat taken at the coming edge; ack one cycle later.
      if (o_mem_stb && !i_mem_stall) begin
        logic [31:0] w;
        stb_cnt++;
        last_addr = o_mem_addr;
        last_sel  = o_mem_sel;
        last_we   = o_mem_we;
        w = mem.exists(int'(o_mem_addr)) ? mem[int'(o_mem_addr)] : 32'h0;
        if (o_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (o_mem_sel[b]) w[8*b +: 8] = o_mem_data[8*b +: 8];
          mem[int'(o_mem_addr)] = w;
          ack_data = '0;
        end else begin
          ack_data = w;
        end
        ack_pending = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_cpu_ack) begin
        ack_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got data 0x%08h with nothing outstanding", o_cpu_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (o_cpu_data !== e) begin
            errors++;
            $display("FAIL ack_data: got 0x%08h expected 0x%08h", o_cpu_data, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input logic [31:0] exp);
    int n = 0;
    @(negedge i_clk);
    while (o_cpu_stall && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (o_cpu_stall) check("req_stall_timeout", 32'(o_cpu_stall), 32'd0);
    exp_q.push_back(exp);
    i_cpu_stb  = 1'b1;
    i_cpu_we   = we;
    i_cpu_addr = addr;
    i_cpu_data = data;
    i_cpu_sel  = sel;
    @(posedge i_clk);
    #1;
    i_cpu_stb  = 1'b0;
    i_cpu_we   = 1'b0;
    i_cpu_sel  = 4'h0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while ((exp_q.size() != 0 || o_cpu_stall) && n < 60) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) check("ack_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input int exp_stb,
                    input string name);
    int s0;
    s0 = stb_cnt;
    cpu_req(1'b0, addr, '0, 4'h0, exp);
    wait_idle();
    check(name, 32'(stb_cnt - s0), 32'(exp_stb));
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                    input string name);
    int s0;
    s0 = stb_cnt;
    cpu_req(1'b1, addr, data, sel, 32'h0);
    wait_idle();
    check(name, 32'(stb_cnt - s0), 32'd1);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int s0, a0;
    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h80]  = 32'hCAFEF00D;
    mem[32'h2C4] = 32'h13579BDF;
    mem[32'h300] = 32'h0BADF00D;

    repeat (3) @(negedge i_clk);
    check("rst_cpu_ack",   32'(o_cpu_ack),   32'd0);
    check("rst_cpu_stall", 32'(o_cpu_stall), 32'd0);
    check("rst_mem_stb",   32'(o_mem_stb),   32'd0);
    check("rst_mem_addr",  o_mem_addr,       32'd0);
    check("rst_cpu_data",  o_cpu_data,       32'd0);
    i_reset_n = 1'b1;

    // 1: cold miss then hit
    rd(32'h40, 32'hDEADBEEF, 1, "t1_miss_stb_count");
    check("t1_mem_addr", last_addr, 32'h40);
    check("t1_mem_sel",  32'(last_sel), 32'hF);
    check("t1_mem_we",   32'(last_we),  32'd0);
    s0 = stb_cnt;
    cpu_req(1'b0, 32'h40, '0, 4'h0, 32'hDEADBEEF);
    @(negedge i_clk);
    check("t1_hit_ack_next_cycle", 32'(o_cpu_ack), 32'd1);
    wait_idle();
    check("t1_hit_no_stb", 32'(stb_cnt - s0), 32'd0);

    // 2: partial write-through, then hit sees the merge
    wr(32'h40, 32'h0000_1234, 4'b0011, "t2_write_stb_count");
    check("t2_mem_we",  32'(last_we),  32'd1);
    check("t2_mem_sel", 32'(last_sel), 32'h3);
    rd(32'h40, 32'hDEAD1234, 0, "t2_read_hit_no_stb");

    // back-to-back hits at one per cycle
    s0 = stb_cnt;
    a0 = ack_cnt;
    for (int i = 0; i < 3; i++) cpu_req(1'b0, 32'h40, '0, 4'h0, 32'hDEAD1234);
    wait_idle();
    check("b2b_hits_no_stb", 32'(stb_cnt - s0), 32'd0);
    check("b2b_hits_acks",   32'(ack_cnt - a0), 32'd3);

    // 3: aliasing on index 0
    rd(32'h80, 32'hCAFEF00D, 1, "t3_alias_miss");
    rd(32'h40, 32'hDEAD1234, 1, "t3_alias_remiss");

    // 4: memory stall during a miss
    s0 = stb_cnt;
    a0 = ack_cnt;
    stall_left = 5;
    cpu_req(1'b0, 32'h2C4, '0, 4'h0, 32'h13579BDF);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("t4_stb_held",   32'(o_mem_stb),   32'd1);
      check("t4_addr_held",  o_mem_addr,       32'h2C4);
      check("t4_sel_held",   32'(o_mem_sel),   32'hF);
      check("t4_cpu_stall",  32'(o_cpu_stall), 32'd1);
      check("t4_no_ack",     32'(o_cpu_ack),   32'd0);
    end
    wait_idle();
    check("t4_single_stb", 32'(stb_cnt - s0), 32'd1);
    check("t4_single_ack", 32'(ack_cnt - a0), 32'd1);

    // write with no lanes: forwarded and acked, line unchanged
    wr(32'h2C4, 32'hFFFF_FFFF, 4'h0, "sel0_write_forwarded");
    check("sel0_mem_sel", 32'(last_sel), 32'h0);
    rd(32'h2C4, 32'h13579BDF, 0, "sel0_line_unchanged");

    // 5: invalidate
    @(negedge i_clk);
    i_invalidate = 1'b1;
    @(posedge i_clk);
    #1;
    i_invalidate = 1'b0;
    rd(32'h40, 32'hDEAD1234, 1, "t5_invalidate_miss");

    // write miss does not allocate
    wr(32'h300, 32'h0000_0055, 4'hF, "wmiss_forwarded");
    rd(32'h300, 32'h0000_0055, 1, "wmiss_no_allocate");

    // 6: reset while waiting on memory
    a0 = ack_cnt;
    cpu_req(1'b0, 32'h80, '0, 4'h0, 32'hCAFEF00D);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    check("t6_rst_cpu_ack",   32'(o_cpu_ack),   32'd0);
    check("t6_rst_cpu_stall", 32'(o_cpu_stall), 32'd0);
    check("t6_rst_mem_stb",   32'(o_mem_stb),   32'd0);
    check("t6_rst_mem_addr",  o_mem_addr,       32'd0);
    check("t6_rst_cpu_data",  o_cpu_data,       32'd0);
    i_reset_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check("t6_no_ack_after_abort", 32'(ack_cnt - a0), 32'd0);
    rd(32'h300, 32'h0000_0055, 1, "t6_valid_cleared");
    rd(32'h300, 32'h0000_0055, 0, "t6_normal_hit_after");

    repeat (2) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
